// File: rtl/pixel_scan_source_if.sv
// ============================================================================
// Module      : pixel_scan_source_if
// Description : Minimal AXI-Stream coordinate channel (tdata/tvalid/tready)
//               used for the hcount and vcount outputs of pixel_scan_source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_scan_source_if #(
    parameter int DATA_W = 11
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/pixel_scan_source.sv
// ============================================================================
// Module      : pixel_scan_source
// Description : Raster-order pixel coordinate generator. Emits (hcount, vcount)
//               on two independent AXI-Stream lanes; a pixel advances only
//               once both lanes have accepted it, keeping lanes pixel-aligned.
//               Optional macro PIXEL_SCAN_CONTINUOUS_EN: after the first start,
//               frames repeat back-to-back until reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_scan_source #(
    parameter int H_PIXELS    = 640,
    parameter int V_PIXELS    = 360,
    parameter int FRAME_CNT_W = 16
) (
    input  wire                    aclk,
    input  wire                    areset,
    input  wire                    start,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    pixel_scan_source_if.master    hcount_axis,
    pixel_scan_source_if.master    vcount_axis
);

    localparam logic [10:0] c_H_LAST = 11'(H_PIXELS - 1);
    localparam logic [9:0]  c_V_LAST = 10'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [10:0]            r_h;
    logic [9:0]             r_v;
    logic                   r_h_sent;
    logic                   r_v_sent;
    logic                   r_busy;
    logic                   r_frame_done;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    logic w_h_valid;
    logic w_v_valid;
    logic w_h_hs;
    logic w_v_hs;
    logic w_pix_done;
    logic w_h_last;
    logic w_v_last;

    // Lane valids are decoded from registers only, so an asynchronous reset
    // drops them immediately without waiting for a clock edge.
    assign w_h_valid  = (r_state == S_SCAN) && !r_h_sent;
    assign w_v_valid  = (r_state == S_SCAN) && !r_v_sent;
    assign w_h_hs     = w_h_valid && hcount_axis.tready;
    assign w_v_hs     = w_v_valid && vcount_axis.tready;
    // A pixel is complete once each lane has either already handshaked or
    // handshakes now; this covers simultaneous and staggered acceptance.
    assign w_pix_done = (r_h_sent || w_h_hs) && (r_v_sent || w_v_hs);
    assign w_h_last   = (r_h == c_H_LAST);
    assign w_v_last   = (r_v == c_V_LAST);

    assign hcount_axis.tdata  = r_h;
    assign hcount_axis.tvalid = w_h_valid;
    assign vcount_axis.tdata  = r_v;
    assign vcount_axis.tvalid = w_v_valid;

    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

    // Scan state machine: coordinate stepping, per-lane sent flags, status.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_h           <= 11'd0;
            r_v           <= 10'd0;
            r_h_sent      <= 1'b0;
            r_v_sent      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_SCAN;
                        r_h      <= 11'd0;
                        r_v      <= 10'd0;
                        r_h_sent <= 1'b0;
                        r_v_sent <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_pix_done) begin
                        r_h_sent <= 1'b0;
                        r_v_sent <= 1'b0;
                        if (!w_h_last) begin
                            r_h <= r_h + 11'd1;
                        end else begin
                            r_h <= 11'd0;
                            if (!w_v_last) begin
                                r_v <= r_v + 10'd1;
                            end else begin
                                r_v          <= 10'd0;
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                            end
                        end
                    end else begin
                        // Remember a lane that has already delivered this
                        // pixel so it is not presented twice.
                        if (w_h_hs) begin
                            r_h_sent <= 1'b1;
                        end
                        if (w_v_hs) begin
                            r_v_sent <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
`ifdef PIXEL_SCAN_CONTINUOUS_EN
                    r_state <= S_SCAN;
                    r_busy  <= 1'b1;
`else
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_scan_source.sv
// ============================================================================
// Module      : tb_pixel_scan_source
// Description : Self-checking bench for pixel_scan_source on a small 4x3 frame
//               with a scoreboard of expected coordinates per lane.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_scan_source;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int FW   = 2;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          areset;
    logic          start;
    logic          busy;
    logic          frame_done;
    logic [FW-1:0] fc;

    pixel_scan_source_if #(.DATA_W(11)) h_if();
    pixel_scan_source_if #(.DATA_W(10)) v_if();

    pixel_scan_source #(
        .H_PIXELS   (H),
        .V_PIXELS   (V),
        .FRAME_CNT_W(FW)
    ) dut (
        .aclk       (clk),
        .areset     (areset),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(fc),
        .hcount_axis(h_if),
        .vcount_axis(v_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int q_h[$];
    int q_v[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                q_h.push_back(x);
                q_v.push_back(y);
            end
        end
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        while (frame_done !== 1'b1 && cycles < bound) begin
            tick();
            cycles++;
        end
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    // Scoreboard: every handshake on a lane must match the next expected coordinate.
    always @(negedge clk) begin
        if (areset === 1'b0) begin
            if (h_if.tvalid && h_if.tready) begin
                if (q_h.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $error("FAIL h_extra: observed %0d expected none", h_if.tdata);
                end else begin
                    chk("h_lane", {21'd0, h_if.tdata}, q_h.pop_front());
                end
            end
            if (v_if.tvalid && v_if.tready) begin
                if (q_v.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $error("FAIL v_extra: observed %0d expected none", v_if.tdata);
                end else begin
                    chk("v_lane", {22'd0, v_if.tdata}, q_v.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        areset      = 1'b1;
        start       = 1'b0;
        h_if.tready = 1'b0;
        v_if.tready = 1'b0;
        tick();
        tick();
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, frame_done}, 32'd0);
        chk("rst_fc",     {30'd0, fc}, 32'd0);
        chk("rst_hvalid", {31'd0, h_if.tvalid}, 32'd0);
        chk("rst_vvalid", {31'd0, v_if.tvalid}, 32'd0);
        chk("rst_hdata",  {21'd0, h_if.tdata}, 32'd0);
        chk("rst_vdata",  {22'd0, v_if.tdata}, 32'd0);
        areset = 1'b0;
        tick();

`ifdef PIXEL_SCAN_CONTINUOUS_EN
        for (int f = 0; f < 5; f++) push_frame();
        h_if.tready = 1'b1;
        v_if.tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < 5; f++) begin
            wait_done(100, cyc);
            chk("cont_latency", cyc, NPIX);
            chk("cont_busy_done", {31'd0, busy}, 32'd1);
            tick();
            chk("cont_fc", {30'd0, fc}, (f + 1) % 4);
            chk("cont_busy", {31'd0, busy}, 32'd1);
        end
        areset = 1'b1;
        chk("cont_q_empty", q_h.size() + q_v.size(), 0);
`else
        // Full frame with both readys held high.
        push_frame();
        h_if.tready = 1'b1;
        v_if.tready = 1'b1;
        start = 1'b1;
        chk("idle_hvalid", {31'd0, h_if.tvalid}, 32'd0);
        tick();
        start = 1'b0;
        chk("first_hvalid", {31'd0, h_if.tvalid}, 32'd1);
        chk("first_vvalid", {31'd0, v_if.tvalid}, 32'd1);
        chk("first_busy",   {31'd0, busy}, 32'd1);
        wait_done(200, cyc);
        chk("frame_latency", cyc, NPIX);
        tick();
        chk("done_pulse_len", {31'd0, frame_done}, 32'd0);
        chk("fc_after_f1",    {30'd0, fc}, 32'd1);
        chk("busy_after_f1",  {31'd0, busy}, 32'd0);
        chk("q_empty_f1", q_h.size() + q_v.size(), 0);

        // Stall hcount lane only; vcount must deliver once and then wait.
        push_frame();
        h_if.tready = 1'b0;
        v_if.tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("stall_vvalid", {31'd0, v_if.tvalid}, 32'd0);
        chk("stall_hvalid", {31'd0, h_if.tvalid}, 32'd1);
        chk("stall_hdata",  {21'd0, h_if.tdata}, 32'd0);
        repeat (3) tick();
        chk("stall_hold_hdata",  {21'd0, h_if.tdata}, 32'd0);
        chk("stall_hold_vvalid", {31'd0, v_if.tvalid}, 32'd0);
        h_if.tready = 1'b1;
        tick();
        chk("resume_hdata",  {21'd0, h_if.tdata}, 32'd1);
        chk("resume_vdata",  {22'd0, v_if.tdata}, 32'd0);
        chk("resume_vvalid", {31'd0, v_if.tvalid}, 32'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200, cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_fc",   {30'd0, fc}, 32'd2);
        chk("ign_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("ign_busy2",   {31'd0, busy}, 32'd0);
        chk("ign_hvalid",  {31'd0, h_if.tvalid}, 32'd0);
        chk("q_empty_f2", q_h.size() + q_v.size(), 0);

        // Alternating readys: hcount on even cycles, vcount on odd cycles.
        push_frame();
        h_if.tready = 1'b0;
        v_if.tready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 200) begin
            h_if.tready = (cyc % 2 == 0);
            v_if.tready = (cyc % 2 == 1);
            tick();
            cyc++;
        end
        chk("alt_done_seen", {31'd0, frame_done}, 32'd1);
        tick();
        chk("alt_fc", {30'd0, fc}, 32'd3);
        chk("q_empty_alt", q_h.size() + q_v.size(), 0);

        // Asynchronous reset in the middle of a frame.
        push_frame();
        h_if.tready = 1'b1;
        v_if.tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(h_if.tdata == 11'd2 && v_if.tdata == 10'd1) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("abort_pos_h", {21'd0, h_if.tdata}, 32'd2);
        chk("abort_pos_v", {22'd0, v_if.tdata}, 32'd1);
        h_if.tready = 1'b0;
        v_if.tready = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        chk("abort_hvalid", {31'd0, h_if.tvalid}, 32'd0);
        chk("abort_vvalid", {31'd0, v_if.tvalid}, 32'd0);
        chk("abort_fc",     {30'd0, fc}, 32'd0);
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        q_h.delete();
        q_v.delete();
        tick();
        areset = 1'b0;
        tick();
        chk("abort_no_done", {31'd0, frame_done}, 32'd0);
        push_frame();
        h_if.tready = 1'b1;
        v_if.tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_hdata", {21'd0, h_if.tdata}, 32'd0);
        chk("restart_vdata", {22'd0, v_if.tdata}, 32'd0);
        wait_done(200, cyc);
        tick();
        chk("restart_fc", {30'd0, fc}, 32'd1);
        chk("q_empty_restart", q_h.size() + q_v.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_scan_source.md
Name: pixel_scan_source

Overview:
- Upstream stage of ray_from_pixel. Generates raster-order pixel coordinates (hcount, vcount) for one frame per start request.
- Drives two independent AXI-Stream coordinate outputs that feed the hcount and vcount inputs of ray_from_pixel.
- Each coordinate pair must be accepted on both outputs before the scan advances. The two ray-generation lanes therefore stay pixel-aligned even when their ready signals differ.

Parameters:
- H_PIXELS, 640, pixels per line; hcount range 0..H_PIXELS-1.
- V_PIXELS, 360, lines per frame; vcount range 0..V_PIXELS-1.
- FRAME_CNT_W, 16, width of the frame counter.

Ports:
- aclk  input  1  clock; all logic is rising-edge.
- areset  input  1  asynchronous, active-high reset.
- start  input  1  begin one frame scan; sampled only in IDLE.
- busy  output  1  high in SCAN and DONE.
- frame_done  output  1  one-cycle pulse after the last pixel is fully accepted.
- frame_count  output  FRAME_CNT_W  count of completed frames; wraps.
- hcount_axis_tdata  output  11  current column.
- hcount_axis_tvalid  output  1  column valid.
- hcount_axis_tready  input  1  column accepted by consumer.
- vcount_axis_tdata  output  10  current row.
- vcount_axis_tvalid  output  1  row valid.
- vcount_axis_tready  input  1  row accepted by consumer.

Behaviour:
- Reset (asynchronous, areset=1):
  - state=IDLE; h=0, v=0; h_sent=0, v_sent=0.
  - busy=0, frame_done=0, frame_count=0.
  - Both tvalid=0; both tdata=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 -> SCAN next cycle with h=0, v=0. Both tvalid rise in that first SCAN cycle (one cycle after start).
  - start=0 -> remain in IDLE.
- Output valids and data:
  - hcount_axis_tvalid = (state==SCAN) && !h_sent; vcount_axis_tvalid = (state==SCAN) && !v_sent.
  - tdata holds h / v (zero-extended) and is stable while its tvalid is high.
- Handshakes:
  - A handshake on a lane is tvalid && tready in the same cycle.
  - A lane's handshake sets its sent flag unless the pixel completes in that cycle.
- Pixel completion:
  - Condition: (h_sent || h handshake) && (v_sent || v handshake). Covers simultaneous handshakes and handshakes in different cycles.
  - On completion, both sent flags clear and the coordinate advances.
  - Maximum throughput: one pixel per cycle when both readys are held high.
- Advance rules:
  - h<H_PIXELS-1 -> h+1.
  - h==H_PIXELS-1 and v<V_PIXELS-1 -> h=0, v+1.
  - h==H_PIXELS-1 and v==V_PIXELS-1 -> DONE; h=0, v=0.
- DONE (one cycle):
  - frame_done=1; frame_count+1, wrapping from all-ones to 0.
  - Next state is IDLE; both tvalid=0 throughout.
- start is ignored in SCAN and DONE; no queuing.
- A tready seen without its matching tvalid has no effect.
- Reset mid-scan aborts the frame immediately:
  - No frame_done pulse; frame_count returns to 0.
  - Both valids drop asynchronously.

Optional Feature:
- Macro: PIXEL_SCAN_CONTINUOUS_EN.
- Defined:
  - DONE returns to SCAN at (0,0) instead of IDLE, so frames repeat with no idle gap beyond the one DONE cycle.
  - start is needed only once after reset; busy stays 1 until reset.
  - frame_done still pulses once per frame.
- Undefined: single-frame-per-start behaviour as above.

Test Plan:
- Reset release, start pulse, both readys held 1 -> tvalid rises one cycle after start; 230400 consecutive pixels with h wrapping 639->0 and v incrementing; last pixel (639,359); frame_done pulses exactly 1 cycle, 1 cycle after the last handshake; frame_count=1; busy=0 afterwards.
- Stall hcount only: hcount_axis_tready=0 for 5 cycles, vcount_axis_tready=1 -> vcount handshakes once, then vcount_axis_tvalid=0; hcount holds tdata=0 with tvalid=1; after hcount_axis_tready rises, pixel (1,0) is presented on the next cycle.
- Alternating readys (hcount ready on even cycles, vcount ready on odd cycles) with H_PIXELS=4, V_PIXELS=2 -> every pixel pair (0..3, 0..1) is delivered exactly once on each lane; no duplicates or skips.
- start asserted during SCAN and during DONE -> ignored; no restart; frame_count increments by 1 only.
- areset=1 asynchronously at pixel (100,50) -> valids drop without waiting for an aclk edge; no frame_done; a following start restarts at (0,0) with frame_count=0.
- PIXEL_SCAN_CONTINUOUS_EN defined, FRAME_CNT_W=2, small frame -> frames repeat back-to-back; frame_count sequence 1,2,3,0,1; busy stays high.
